ahb3lite_mst_bridge: RTL
========================

Name: ahb3lite_mst_bridge

Overview:
- AHB3-Lite master that converts a simple valid/ready command stream into single-beat pipelined AHB3-Lite transfers.
- Returns one in-order response per command.
- Sits between internal requesters (DMA engines, debug ports, CPU load/store units) and the AHB3-Lite interconnect, driving the SRAM and peripheral slaves.
- The address phase of command N+1 overlaps the data phase of command N.

Parameters:
HADDR_SIZE, 32, address bus width in bits
HDATA_SIZE, 32, data bus width in bits; 8..1024, power of 2
HPROT_VALUE, 4'b0011, constant HPROT driven on every transfer (data, privileged)

Ports:
HRESETn  input  1  asynchronous active-low reset
HCLK  input  1  clock, rising edge
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_addr  input  HADDR_SIZE  byte address; must be aligned to cmd_size
cmd_write  input  1  1 = write, 0 = read
cmd_size  input  3  HSIZE encoding; must not exceed HDATA_SIZE
cmd_wdata  input  HDATA_SIZE  write data, bus-lane aligned; no lane steering is done
rsp_valid  output  1  one-cycle response pulse; no backpressure
rsp_rdata  output  HDATA_SIZE  read data; value for writes is don't-care
rsp_err  output  1  transfer ended with an ERROR response
HADDR  output  HADDR_SIZE  AHB address
HWRITE  output  1  AHB write
HSIZE  output  3  AHB size
HBURST  output  3  always HBURST_SINGLE
HPROT  output  4  always HPROT_VALUE
HTRANS  output  2  IDLE or NONSEQ only
HMASTLOCK  output  1  always 0
HWDATA  output  HDATA_SIZE  AHB write data
HRDATA  input  HDATA_SIZE  AHB read data
HREADY  input  1  interconnect HREADY (multiplexed HREADYOUT)
HRESP  input  1  AHB response

Behaviour:
- Two internal stages:
  - AP (address phase): ap_valid, addr, write, size, wdata.
  - DP (data phase): dp_valid, write, wdata.
- Reset values:
  - ap_valid = dp_valid = 0; HTRANS = IDLE.
  - HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - cmd_ready = 1 once HRESETn is released.
- Bus outputs:
  - HADDR, HWRITE and HSIZE are driven from AP registers.
  - HWDATA is driven from the DP wdata register.
- cancel = dp_valid & HRESP (covers both cycles of an ERROR response).
- HTRANS = NONSEQ when ap_valid & ~cancel; otherwise IDLE.
- cmd_ready = ~cancel & (~ap_valid | HREADY).
- On HREADY=1 & ~cancel:
  - DP <= AP; dp_valid <= ap_valid.
  - AP <= accepted command, or ap_valid <= 0 if none accepted.
- On HREADY=0: AP and DP hold; outputs remain stable, as required by AHB.
- ERROR handling (two-cycle ERROR):
  - Cycle 1 (HRESP=1, HREADY=0): HTRANS forced IDLE; pending AP is held, not dropped.
  - Cycle 2 (HRESP=1, HREADY=1): DP completes with error; AP is not advanced to DP; dp_valid <= 0.
  - Next cycle: held AP is re-presented as NONSEQ. The cancelled command is reissued, never lost.
- Response: when HREADY=1 & dp_valid, the next cycle gives rsp_valid=1, rsp_rdata = HRDATA sampled, rsp_err = HRESP sampled. Otherwise rsp_valid=0.
- Latency, zero-wait slave:
  - Command accepted at edge T.
  - NONSEQ on bus in cycle T+1.
  - Data phase in T+2.
  - rsp_valid in T+3.
- Throughput: 1 transfer/cycle back-to-back; responses strictly in command order.
- Wait states: each HREADY=0 cycle in the data phase adds one cycle of latency to that response and to all later ones.
- Slave-side stalls (e.g. SRAM read-after-partial-write contention) are absorbed through HREADY with no special logic.
- Reset asserted mid-transfer: all state cleared asynchronously, no response is issued for in-flight commands, HTRANS = IDLE immediately.
- Misaligned or oversized commands are out of scope (requester's responsibility). The bus is driven as given; a simulation-only assertion flags them.

Decomposition:
- Reuse the existing ahb3lite_pkg for HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_* and HRESP_OKAY/ERROR; add no new constants.
- No sub-module: a single flat module with AP/DP register stages.

Test Plan:
- Single read, addr 0x40, zero-wait SRAM preloaded with 0xDEADBEEF at 0x40 -> NONSEQ at T+1, rsp_valid at T+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC (data 1..4), then four reads -> HTRANS NONSEQ every cycle; HWDATA one cycle behind HADDR; reads return 1, 2, 3, 4 in order.
- Byte write 0xAA to 0x101 (HSIZE=BYTE), then word read 0x100 from SRAM initialised to 0x11223344 -> HWDATA lane [15:8]=0xAA; read returns 0x1122AA44.
- Slave inserts 3 wait states on the read at 0x8 with the next command pending -> HADDR/HTRANS held stable for 3 cycles, rsp delayed 3 cycles, following command issued after.
- ERROR on the write to 0x20 with a read of 0x24 pending -> HTRANS IDLE during both ERROR cycles; rsp_err=1 for 0x20; 0x24 then reissued and returns OKAY data.
- HRESETn asserted while a read is in data phase with one command in AP -> HTRANS=IDLE immediately, rsp_valid stays 0, cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used by masters and slaves on this interconnect.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_mst_bridge_if.sv
// AHB3-Lite bus bundle between the bridge (master) and the interconnect (slave side).
interface ahb3lite_mst_bridge_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic [HADDR_SIZE-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb3lite_mst_bridge_chk.sv
// Simulation checker for the bridge command port: accepted commands must be
// aligned to their size and no wider than the data bus.
module ahb3lite_mst_bridge_chk #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    input logic                  cmd_valid,
    input logic                  cmd_ready,
    input logic [HADDR_SIZE-1:0] cmd_addr,
    input logic [2:0]            cmd_size
);

    function automatic logic cmd_legal(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
        logic [HADDR_SIZE-1:0] mask;
        mask = (HADDR_SIZE'(1) << size) - HADDR_SIZE'(1);
        return ((addr & mask) == {HADDR_SIZE{1'b0}}) && ((32'd8 << size) <= 32'(HDATA_SIZE));
    endfunction

    a_cmd_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (cmd_valid && cmd_ready) |-> cmd_legal(cmd_addr, cmd_size));

endmodule

// File: rtl/ahb3lite_mst_bridge.sv
// Command-stream to AHB3-Lite master: single NONSEQ transfers, address phase of
// the next command overlapped with the data phase of the current one, one
// in-order response per command. An ERROR response cancels the pending address
// phase, which is then re-presented rather than dropped.
module ahb3lite_mst_bridge
    import ahb3lite_pkg::*;
#(
    parameter int         HADDR_SIZE  = 32,
    parameter int         HDATA_SIZE  = 32,
    parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic [HDATA_SIZE-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,

    ahb3lite_mst_bridge_if.master ahb
);

    // Address-phase stage
    logic                  ap_valid_q, ap_valid_d;
    logic [HADDR_SIZE-1:0] ap_addr_q,  ap_addr_d;
    logic                  ap_write_q, ap_write_d;
    logic [2:0]            ap_size_q,  ap_size_d;
    logic [HDATA_SIZE-1:0] ap_wdata_q, ap_wdata_d;

    // Data-phase stage
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [HDATA_SIZE-1:0] dp_wdata_q, dp_wdata_d;

    // Response registers
    logic                  rsp_valid_q, rsp_valid_d;
    logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic cancel_s;
    logic accept_s;
    logic advance_s;

    // An ERROR on the transfer in data phase blocks the pipeline for both ERROR cycles.
    assign cancel_s  = dp_valid_q & (ahb.HRESP == HRESP_ERROR);
    assign advance_s = ahb.HREADY & ~cancel_s;
    assign cmd_ready = ~cancel_s & (~ap_valid_q | ahb.HREADY);
    assign accept_s  = cmd_valid & cmd_ready;

    // Next-state for the AP/DP pipeline and the response registers.
    always_comb begin
        ap_valid_d  = ap_valid_q;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        // Data phase: take over the address phase when the bus moves on; on the
        // final ERROR cycle the errored transfer retires and AP stays put.
        if (advance_s) begin
            dp_valid_d = ap_valid_q;
            dp_write_d = ap_write_q;
            dp_wdata_d = ap_wdata_q;
        end else if (ahb.HREADY) begin
            dp_valid_d = 1'b0;
        end else begin
            dp_valid_d = dp_valid_q;
        end

        // Address phase: an accepted command loads AP (also legal while AP was
        // empty during a wait state); otherwise AP empties once it has moved on.
        if (accept_s) begin
            ap_valid_d = 1'b1;
            ap_addr_d  = cmd_addr;
            ap_write_d = cmd_write;
            ap_size_d  = cmd_size;
            ap_wdata_d = cmd_wdata;
        end else if (advance_s) begin
            ap_valid_d = 1'b0;
        end else begin
            ap_valid_d = ap_valid_q;
        end

        // A data phase completing this cycle produces the response next cycle.
        if (ahb.HREADY && dp_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dp_write_q ? {HDATA_SIZE{1'b0}} : ahb.HRDATA;
            rsp_err_d   = (ahb.HRESP == HRESP_ERROR);
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // Pipeline and response state; reset empties both stages so the bus goes IDLE at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_q  <= 1'b0;
            ap_addr_q   <= {HADDR_SIZE{1'b0}};
            ap_write_q  <= 1'b0;
            ap_size_q   <= 3'b000;
            ap_wdata_q  <= {HDATA_SIZE{1'b0}};
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= {HDATA_SIZE{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {HDATA_SIZE{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ahb.HADDR     = ap_addr_q;
    assign ahb.HWRITE    = ap_write_q;
    assign ahb.HSIZE     = ap_size_q;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HPROT     = HPROT_VALUE;
    assign ahb.HTRANS    = (ap_valid_q && !cancel_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HWDATA    = dp_wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
